fifo_refill_scheduler: RTL and testbench



---
 rtl/fifo_refill_scheduler_pkg.sv | 22 ++
 rtl/fifo_refill_scheduler_if.sv | 17 +
 rtl/fifo_refill_scheduler_rr_arbiter.sv | 34 +++
 rtl/fifo_refill_scheduler.sv | 123 ++++++++++++
 tb/tb_fifo_refill_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_refill_scheduler_pkg.sv
// fifo_sched_pkg: shared constants and types for fifo_refill_scheduler.
//   DEF_BURST_LEN / DEF_CAP : default burst length and usable FIFO capacity
//   state_t                 : scheduler state {IDLE, REQ}
//   clog2()                 : ceil(log2(value)) for parameter derivation
package fifo_sched_pkg;

   localparam int DEF_BURST_LEN = 8;
   localparam int DEF_CAP       = 28;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int p = 1; p < value; p = p * 2) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_refill_scheduler_if.sv
// fifo_refill_scheduler_if: refill request channel toward the memory reader.
//   req_valid : request pending (driven by scheduler)
//   req_idx   : target FIFO of the pending request (driven by scheduler)
//   req_ready : read channel accepts the request (driven by reader)
// Handshake: a request transfers on a clock edge where req_valid && req_ready.
// While req_valid is high, req_idx is held stable until that edge; req_valid
// never depends combinationally on req_ready.
interface fifo_refill_scheduler_if #(
   parameter int IDX_W = 3
);
   logic             req_valid;
   logic [IDX_W-1:0] req_idx;
   logic             req_ready;

   modport master (output req_valid, output req_idx, input req_ready);
   modport slave  (input req_valid, input req_idx, output req_ready);
endinterface

// File: rtl/fifo_refill_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   eligible : one bit per FIFO
//   ptr      : highest-priority index this round
//   found    : some index is eligible
//   idx      : first eligible index at or after ptr, wrapping around
module rr_arbiter #(
   parameter int N_FIFO = 8,
   parameter int IDX_W  = 3
) (
   input  logic [N_FIFO-1:0] eligible,
   input  logic [IDX_W-1:0]  ptr,
   output logic              found,
   output logic [IDX_W-1:0]  idx
);

   logic [IDX_W-1:0] cand;

   // Scan offsets from farthest to nearest so the nearest eligible index
   // (smallest offset from ptr) is the last one written. N_FIFO is a power
   // of two, so IDX_W-bit addition wraps naturally.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_FIFO - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k);
         if (eligible[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_refill_scheduler.sv
// fifo_refill_scheduler: shares one memory read channel among N_FIFO FIFOs.
// Tracks free-slot credits and remaining bursts per FIFO and issues one
// burst-refill request at a time in round-robin order. Credits are reserved
// at grant time, so in-flight beats can never overflow a FIFO.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_cfg_valid/i_cfg_idx/i_cfg_bursts : overwrite remaining bursts of a FIFO
//   i_deq          : per-FIFO dequeue pulse, returns one credit each
//   req            : request channel (master side)
//   o_done         : FIFO has no bursts left and is fully drained
//   o_err          : sticky credit-overflow flag
//   o_dbg_state    : scheduler state
module fifo_refill_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int N_FIFO    = 8,
   parameter int IDX_W     = clog2(N_FIFO),
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int CAP       = DEF_CAP,
   parameter int CRED_W    = clog2(CAP + 1),
   parameter int BCNT_W    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cfg_valid,
   input  logic [IDX_W-1:0]      i_cfg_idx,
   input  logic [BCNT_W-1:0]     i_cfg_bursts,
   input  logic [N_FIFO-1:0]     i_deq,
   fifo_refill_scheduler_if.master req,
   output logic [N_FIFO-1:0]     o_done,
   output logic                  o_err,
   output state_t                o_dbg_state
);

   localparam logic [CRED_W-1:0] CAP_C   = CRED_W'(CAP);
   localparam logic [CRED_W-1:0] BURST_C = CRED_W'(BURST_LEN);

   state_t             state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [N_FIFO-1:0]  eligible;
   logic [N_FIFO-1:0]  ovf;
   logic               arb_found;
   logic [IDX_W-1:0]   arb_idx;
   logic               hs;

   assign hs = (state_q == REQ) && req.req_ready;

   for (genvar g = 0; g < N_FIFO; g++) begin : g_fifo
      logic [CRED_W-1:0] credit_q;
      logic [CRED_W-1:0] cred_inc;
      logic [BCNT_W-1:0] remaining_q;
      logic              grant;

      assign grant = hs && (req.req_idx == IDX_W'(g));

      // A dequeue at full credit is an accounting error: saturate at CAP,
      // then the grant reservation (if any) is applied on top.
      assign cred_inc = (i_deq[g] && credit_q != CAP_C) ? credit_q + CRED_W'(1) : credit_q;
      assign ovf[g]   = i_deq[g] && (credit_q == CAP_C);

      assign eligible[g] = (remaining_q != '0) && (credit_q >= BURST_C);
      assign o_done[g]   = (remaining_q == '0) && (credit_q == CAP_C);

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            credit_q    <= CAP_C;
            remaining_q <= '0;
         end else begin
            credit_q <= grant ? cred_inc - BURST_C : cred_inc;
            // Config overwrites; a grant on a FIFO reconfigured to 0 while
            // its request was pending leaves remaining at 0.
            if (i_cfg_valid && i_cfg_idx == IDX_W'(g))
               remaining_q <= i_cfg_bursts;
            else if (grant && remaining_q != '0)
               remaining_q <= remaining_q - BCNT_W'(1);
         end
      end
   end

   rr_arbiter #(
      .N_FIFO (N_FIFO),
      .IDX_W  (IDX_W)
   ) u_arb (
      .eligible (eligible),
      .ptr      (ptr_q),
      .found    (arb_found),
      .idx      (arb_idx)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         req.req_valid <= 1'b0;
         req.req_idx   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  req.req_idx   <= arb_idx;
                  req.req_valid <= 1'b1;
                  state_q       <= REQ;
               end
            end
            REQ: begin
               if (req.req_ready) begin
                  ptr_q         <= req.req_idx + IDX_W'(1);
                  req.req_valid <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) o_err <= 1'b0;
      else       o_err <= o_err | (|ovf);
   end

   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fifo_refill_scheduler.sv
module tb_fifo_refill_scheduler;
   import fifo_sched_pkg::*;

   localparam int N    = 8;
   localparam int IW   = 3;
   localparam int BL   = 8;
   localparam int CAPV = 28;
   localparam int BW   = 16;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic [IW-1:0] cfg_idx;
   logic [BW-1:0] cfg_bursts;
   logic [N-1:0]  deq;
   logic [N-1:0]  done;
   logic          err;
   state_t        dbg_state;

   fifo_refill_scheduler_if #(.IDX_W(IW)) req_if ();

   fifo_refill_scheduler #(
      .N_FIFO(N), .IDX_W(IW), .BURST_LEN(BL), .CAP(CAPV), .CRED_W(5), .BCNT_W(BW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cfg_valid  (cfg_valid),
      .i_cfg_idx    (cfg_idx),
      .i_cfg_bursts (cfg_bursts),
      .i_deq        (deq),
      .req          (req_if),
      .o_done       (done),
      .o_err        (err),
      .o_dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   logic [IW-1:0] exp_q[$];    // expected grant order
   logic [IW-1:0] grant_q[$];  // grants observed on the DUT channel

   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Abstract view: a credit and a burst count per FIFO, one pending request
   // slot, a rotating start point for the search.
   int m_cred[N];
   int m_rem[N];
   int m_ptr;
   bit m_pend;
   int m_pidx;
   bit m_err;

   function automatic logic [N-1:0] model_done();
      logic [N-1:0] d;
      for (int i = 0; i < N; i++) d[i] = (m_rem[i] == 0) && (m_cred[i] == CAPV);
      return d;
   endfunction

   task automatic model_update();
      bit hs;
      bit found;
      int pick;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_cred[i] = CAPV;
            m_rem[i]  = 0;
         end
         m_ptr = 0; m_pend = 0; m_pidx = 0; m_err = 0;
         return;
      end
      hs    = m_pend && req_if.req_ready;
      found = 0;
      pick  = 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (!found && m_rem[j] != 0 && m_cred[j] >= BL) begin
            found = 1;
            pick  = j;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (deq[i]) begin
            if (m_cred[i] == CAPV) m_err = 1;
            else m_cred[i]++;
         end
      end
      if (hs) begin
         m_cred[m_pidx] -= BL;
         if (m_rem[m_pidx] > 0) m_rem[m_pidx]--;
         m_ptr  = (m_pidx + 1) % N;
         m_pend = 0;
      end else if (!m_pend && found) begin
         m_pend = 1;
         m_pidx = pick;
      end
      if (cfg_valid) m_rem[cfg_idx] = cfg_bursts;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      if (!rst && req_if.req_valid && req_if.req_ready) grant_q.push_back(req_if.req_idx);
      model_update();
      @(posedge clk);
      #1;
      check("m_valid", req_if.req_valid, m_pend);
      check("m_idx",   req_if.req_idx,   m_pidx);
      check("m_done",  done,             model_done());
      check("m_err",   err,              m_err);
   endtask

   task automatic idle_inputs();
      cfg_valid  = 1'b0;
      cfg_idx    = '0;
      cfg_bursts = '0;
      deq        = '0;
   endtask

   task automatic cfg_step(input int idx, input int bursts);
      cfg_valid  = 1'b1;
      cfg_idx    = IW'(idx);
      cfg_bursts = BW'(bursts);
      step();
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      req_if.req_ready = 1'b0;
      rst = 1'b1;
      step();
      check("rst_valid", req_if.req_valid, 0);
      check("rst_idx",   req_if.req_idx,   0);
      check("rst_done",  done,             8'hFF);
      check("rst_err",   err,              0);
      check("rst_state", dbg_state,        IDLE);
      rst = 1'b0;
      grant_q.delete();
   endtask

   task automatic wait_valid(input int budget);
      int k;
      k = 0;
      while (!req_if.req_valid && k < budget) begin
         step();
         k++;
      end
      check("wait_valid", req_if.req_valid, 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          cfg_v;
      logic [IW-1:0] cfg_i;
      logic [BW-1:0] cfg_b;
      logic [N-1:0]  deq;
      logic          ready;
      logic          exp_valid;
      logic [IW-1:0] exp_idx;
      logic [N-1:0]  exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      // FIFO 3, two bursts, ready held high: requests one per two cycles.
      vecs[0] = '{1'b1, 3'd3, 16'd2, 8'h00, 1'b1, 1'b0, 3'd0, 8'hF7};
      vecs[1] = '{1'b0, 3'd0, 16'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hF7};
      vecs[2] = '{1'b0, 3'd0, 16'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'hF7};
      vecs[3] = '{1'b0, 3'd0, 16'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'hF7};
      vecs[4] = '{1'b0, 3'd0, 16'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'hF7};
      vecs[5] = '{1'b0, 3'd0, 16'd0, 8'h00, 1'b1, 1'b0, 3'd3, 8'hF7};

      rst = 1'b1;
      req_if.req_ready = 1'b0;
      idle_inputs();

      // --- table-driven: basic two-burst refill ---
      do_reset();
      for (int r = 0; r < 6; r++) begin
         cfg_valid        = vecs[r].cfg_v;
         cfg_idx          = vecs[r].cfg_i;
         cfg_bursts       = vecs[r].cfg_b;
         deq              = vecs[r].deq;
         req_if.req_ready = vecs[r].ready;
         step();
         check("vec_valid", req_if.req_valid, vecs[r].exp_valid);
         check("vec_idx",   req_if.req_idx,   vecs[r].exp_idx);
         check("vec_done",  done,             vecs[r].exp_done);
      end
      idle_inputs();
      check("credit3", dut.g_fifo[3].credit_q, 12);

      // --- round-robin order with wrap-around ---
      do_reset();
      req_if.req_ready = 1'b1;
      exp_q = '{3'd0, 3'd1, 3'd5, 3'd0};
      cfg_step(0, 1);
      cfg_step(1, 1);
      cfg_step(5, 1);
      for (int k = 0; k < 8; k++) step();
      cfg_step(0, 1);
      for (int k = 0; k < 6; k++) step();
      check("rr_count", grant_q.size(), exp_q.size());
      while (exp_q.size() > 0 && grant_q.size() > 0)
         check("rr_order", grant_q.pop_front(), exp_q.pop_front());

      // --- credit stall and release by dequeues ---
      do_reset();
      req_if.req_ready = 1'b1;
      cfg_step(2, 4);
      for (int k = 0; k < 12; k++) step();
      check("stall_grants", grant_q.size(), 3);
      check("stall_valid",  req_if.req_valid, 0);
      check("stall_credit", dut.g_fifo[2].credit_q, 4);
      for (int k = 0; k < 4; k++) begin
         deq = 8'h04;
         step();
         check("deq_no_valid", req_if.req_valid, 0);
      end
      idle_inputs();
      check("credit8", dut.g_fifo[2].credit_q, 8);
      step();
      check("resume_valid", req_if.req_valid, 1);
      check("resume_idx",   req_if.req_idx,   2);
      step();

      // --- dequeue and grant on the same FIFO in one cycle ---
      do_reset();
      cfg_step(4, 2);
      wait_valid(5);
      req_if.req_ready = 1'b1;
      step();
      req_if.req_ready = 1'b0;
      check("c4_after_grant", dut.g_fifo[4].credit_q, 20);
      wait_valid(5);
      deq = 8'h10;
      req_if.req_ready = 1'b1;
      step();
      idle_inputs();
      req_if.req_ready = 1'b0;
      check("c4_net", dut.g_fifo[4].credit_q, 13);
      check("c4_err", err, 0);

      // --- overflow sets sticky error ---
      do_reset();
      deq = 8'h40;
      step();
      idle_inputs();
      check("ovf_err",    err, 1);
      check("ovf_credit", dut.g_fifo[6].credit_q, 28);
      for (int k = 0; k < 3; k++) step();
      check("ovf_sticky", err, 1);

      // --- config and handshake on the same index ---
      do_reset();
      cfg_step(1, 3);
      wait_valid(5);
      cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_bursts = 16'd5;
      req_if.req_ready = 1'b1;
      step();
      idle_inputs();
      req_if.req_ready = 1'b0;
      check("cfg_wins_rem",  dut.g_fifo[1].remaining_q, 5);
      check("cfg_wins_cred", dut.g_fifo[1].credit_q, 20);

      // --- config of 0 while pending does not withdraw ---
      do_reset();
      cfg_step(2, 1);
      wait_valid(5);
      cfg_step(2, 0);
      check("zero_keep_valid", req_if.req_valid, 1);
      req_if.req_ready = 1'b1;
      step();
      check("zero_hs_valid", req_if.req_valid, 0);
      check("zero_rem",      dut.g_fifo[2].remaining_q, 0);
      for (int k = 0; k < 3; k++) step();
      check("zero_no_more", req_if.req_valid, 0);

      // --- reset while a request is pending ---
      do_reset();
      cfg_step(7, 1);
      wait_valid(5);
      do_reset();

      // --- randomized traffic against the model ---
      do_reset();
      for (int c = 0; c < 600; c++) begin
         idle_inputs();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0 && (m_cred[i] < CAPV || $urandom_range(0, 199) == 0))
               deq[i] = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) begin
            cfg_valid  = 1'b1;
            cfg_idx    = IW'($urandom_range(0, N - 1));
            cfg_bursts = BW'($urandom_range(0, 3));
         end
         req_if.req_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
